// File: rtl/pwm_pkg.sv
// Shared definitions for the counter-driven PWM block:
// FSM state encoding and duty saturation.
package pwm_pkg;

   localparam logic ST_IDLE    = 1'b0;
   localparam logic ST_PENDING = 1'b1;

   typedef enum logic {
      S_IDLE    = ST_IDLE,
      S_PENDING = ST_PENDING
   } pwm_state_t;

   // Clamp a requested duty to the full period 2^width.
   function automatic logic [31:0] sat_duty(
      input logic [31:0] d,
      input int          width
   );
      logic [31:0] lim;
      lim = 32'd1 << width;
      return (d > lim) ? lim : d;
   endfunction

endpackage

// File: rtl/pwm_from_counter_if.sv
// Duty-cycle update handshake between a requester
// and the PWM block.
interface pwm_from_counter_if #(
   parameter int CNT_WIDTH = 3
);

   logic [CNT_WIDTH:0] duty_in;
   logic               duty_valid;
   logic               duty_ready;

   modport master (
      output duty_in,
      output duty_valid,
      input  duty_ready
   );

   modport slave (
      input  duty_in,
      input  duty_valid,
      output duty_ready
   );

endinterface

// File: rtl/pwm_from_counter_wrap_detect.sv
// Detects the MAX->0 transition of the upstream counter
// and registers a one-cycle wrap pulse.
module wrap_detect #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] counter,
   output logic             wrap,
   output logic             wrap_pulse
);

   localparam logic [WIDTH-1:0] MAX = '1;

   logic [WIDTH-1:0] cnt_q;

   // A jump to zero from anything but MAX is not a period boundary.
   assign wrap = (counter == '0) && (cnt_q == MAX);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q      <= '0;
         wrap_pulse <= 1'b0;
      end else begin
         cnt_q      <= counter;
         wrap_pulse <= wrap;
      end
   end

endmodule

// File: rtl/pwm_from_counter.sv
// PWM generator fed by a free-running counter, with
// double-buffered duty updates applied at period boundaries.
module pwm_from_counter
   import pwm_pkg::*;
#(
   parameter int CNT_WIDTH  = 3,
   parameter int DUTY_RESET = 0,
   parameter bit INVERT     = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [CNT_WIDTH-1:0] counter,
   input  logic                 enable,
   pwm_from_counter_if.slave    duty,
   output logic                 pwm_out,
   output logic                 wrap_pulse,
   output logic                 update_done
);

   localparam int DW = CNT_WIDTH + 1;

   pwm_state_t    state, state_nx;
   logic [DW-1:0] shadow, shadow_nx;
   logic [DW-1:0] active, active_nx;
   logic [DW-1:0] eff;
   logic          upd_nx;
   logic          pwm_nx;
   logic          wrap;

   wrap_detect #(
      .WIDTH (CNT_WIDTH)
   ) u_wrap (
      .clk        (clk),
      .reset_n    (reset_n),
      .counter    (counter),
      .wrap       (wrap),
      .wrap_pulse (wrap_pulse)
   );

   assign duty.duty_ready = (state == S_IDLE);

   always_comb begin
      state_nx  = state;
      shadow_nx = shadow;
      active_nx = active;
      upd_nx    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (duty.duty_valid) begin
               shadow_nx = DW'(sat_duty(32'(duty.duty_in), CNT_WIDTH));
               state_nx  = S_PENDING;
            end
         end
         S_PENDING: begin
            if (wrap) begin
               active_nx = shadow;
               upd_nx    = 1'b1;
               state_nx  = S_IDLE;
            end
         end
      endcase
   end

   // The pending duty already governs the count-0 sample of its period.
   assign eff    = (state == S_PENDING && wrap) ? shadow : active;
   assign pwm_nx = INVERT ^ (enable && ({1'b0, counter} < eff));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         shadow      <= '0;
         active      <= DW'(DUTY_RESET);
         pwm_out     <= INVERT;
         update_done <= 1'b0;
      end else begin
         state       <= state_nx;
         shadow      <= shadow_nx;
         active      <= active_nx;
         pwm_out     <= pwm_nx;
         update_done <= upd_nx;
      end
   end

endmodule
